// File: rtl/constants_pkg.sv
// rtl/constants_pkg.sv - shared widths, arbiter state/owner types and limits
package constants_pkg;

    localparam int MEMORY_ADDRESS_BITS = 8;
    localparam int MEMORY_DATA_BITS    = 8;

    // Consecutive LS grants tolerated while IF waits before IF is forced in.
    localparam int ARB_STARVE_LIMIT = 3;

    typedef enum bit [2:0] {
        ARB_IDLE,
        ARB_RD_ISSUE,
        ARB_RD_CAPTURE,
        ARB_WR_SETUP,
        ARB_WR_COMMIT
    } arb_state_t;

    typedef enum bit {
        OWN_IF,
        OWN_LS
    } owner_t;

endpackage

// File: rtl/mem_grant_select.sv
// rtl/mem_grant_select.sv - LS-priority winner pick with saturating IF starvation counter
//
// Ports:
//   clk, reset   clock, asynchronous active-low reset
//   if_req       instruction fetch request
//   ls_req       load/store request
//   grant_now    arbiter is idle and a grant is being made this edge
//   win_ls       combinational: 1 = LS wins, 0 = IF wins (valid when grant_now)
module mem_grant_select
    import constants_pkg::*;
#(
    parameter int STARVE_LIMIT = ARB_STARVE_LIMIT
) (
    input  logic clk,
    input  logic reset,
    input  logic if_req,
    input  logic ls_req,
    input  logic grant_now,
    output logic win_ls
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt;
    logic             starved;

    assign starved = (starve_cnt == CNT_W'(STARVE_LIMIT)) && if_req;
    assign win_ls  = ls_req && !starved;

    // Outside IDLE a waiting IF always holds if_req, so clearing on any
    // edge with if_req low is the same as clearing on IDLE edges only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (grant_now && win_ls && if_req) begin
            if (starve_cnt != CNT_W'(STARVE_LIMIT)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end else if (grant_now || !if_req) begin
            starve_cnt <= '0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester sequencer for the single-port RAM
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   if_req/if_addr             IF read request (held until if_done)
//   if_gnt/if_done/if_rdata    IF grant pulse, done pulse, read data
//   ls_req/ls_we/ls_addr/ls_wdata  LS request, 1 = store, address, store data
//   ls_gnt/ls_done/ls_rdata    LS grant pulse, done pulse, load data
//   mem_address/mem_out_en/mem_write_en  RAM address, read enable, write strobe
//   mem_wr_data/mem_drive_en   write data and its tristate drive enable
//   mem_rd_data                RAM data net as read back
module mem_port_arbiter
    import constants_pkg::*;
#(
    parameter int ADDR_BITS    = MEMORY_ADDRESS_BITS,
    parameter int DATA_BITS    = MEMORY_DATA_BITS,
    parameter int STARVE_LIMIT = ARB_STARVE_LIMIT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 if_req,
    input  logic [ADDR_BITS-1:0] if_addr,
    output logic                 if_gnt,
    output logic                 if_done,
    output logic [DATA_BITS-1:0] if_rdata,
    input  logic                 ls_req,
    input  logic                 ls_we,
    input  logic [ADDR_BITS-1:0] ls_addr,
    input  logic [DATA_BITS-1:0] ls_wdata,
    output logic                 ls_gnt,
    output logic                 ls_done,
    output logic [DATA_BITS-1:0] ls_rdata,
    output logic [ADDR_BITS-1:0] mem_address,
    output logic                 mem_out_en,
    output logic                 mem_write_en,
    output logic [DATA_BITS-1:0] mem_wr_data,
    output logic                 mem_drive_en,
    input  logic [DATA_BITS-1:0] mem_rd_data
);

    arb_state_t state;
    owner_t     owner;
    logic       grant_now;
    logic       win_ls;

    assign grant_now = (state == ARB_IDLE) && (if_req || ls_req);

    mem_grant_select #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_grant_select (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .ls_req    (ls_req),
        .grant_now (grant_now),
        .win_ls    (win_ls)
    );

    // mem_address and mem_wr_data double as the latched request fields.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ARB_IDLE;
            owner        <= OWN_IF;
            if_gnt       <= 1'b0;
            if_done      <= 1'b0;
            if_rdata     <= '0;
            ls_gnt       <= 1'b0;
            ls_done      <= 1'b0;
            ls_rdata     <= '0;
            mem_address  <= '0;
            mem_out_en   <= 1'b0;
            mem_write_en <= 1'b0;
            mem_wr_data  <= '0;
            mem_drive_en <= 1'b0;
        end else begin
            if_gnt  <= 1'b0;
            if_done <= 1'b0;
            ls_gnt  <= 1'b0;
            ls_done <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (grant_now) begin
                        if (win_ls) begin
                            owner       <= OWN_LS;
                            ls_gnt      <= 1'b1;
                            mem_address <= ls_addr;
                            if (ls_we) begin
                                mem_wr_data  <= ls_wdata;
                                mem_drive_en <= 1'b1;
                                state        <= ARB_WR_SETUP;
                            end else begin
                                mem_out_en <= 1'b1;
                                state      <= ARB_RD_ISSUE;
                            end
                        end else begin
                            owner       <= OWN_IF;
                            if_gnt      <= 1'b1;
                            mem_address <= if_addr;
                            mem_out_en  <= 1'b1;
                            state       <= ARB_RD_ISSUE;
                        end
                    end
                end
                ARB_RD_ISSUE: begin
                    state <= ARB_RD_CAPTURE;
                end
                ARB_RD_CAPTURE: begin
                    if (owner == OWN_LS) begin
                        ls_rdata <= mem_rd_data;
                        ls_done  <= 1'b1;
                    end else begin
                        if_rdata <= mem_rd_data;
                        if_done  <= 1'b1;
                    end
                    mem_out_en <= 1'b0;
                    state      <= ARB_IDLE;
                end
                ARB_WR_SETUP: begin
                    mem_write_en <= 1'b1;
                    state        <= ARB_WR_COMMIT;
                end
                ARB_WR_COMMIT: begin
                    mem_write_en <= 1'b0;
                    mem_drive_en <= 1'b0;
                    ls_done      <= 1'b1;
                    state        <= ARB_IDLE;
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences the single-port `ram` and shares it between two requesters: instruction fetch (IF) and the load/store path (LS). It owns all RAM control pins (`address`, `out_en`, `write_en`, write-data drive), so the execution FSM no longer drives them directly. LS has priority, with a starvation guard for IF. Every access is a fixed two-cycle RAM transaction that ends in a one-cycle `done` pulse.

## Interface
- `ADDR_BITS`, default `MEMORY_ADDRESS_BITS`: RAM address width
- `DATA_BITS`, default `MEMORY_DATA_BITS`: RAM data width
- `STARVE_LIMIT`, default 3: number of consecutive LS grants while IF waits; after that many, the next grant goes to IF (must be ≥1)

Ports:
- `clk` in 1: single clock; all state changes on the rising edge
- `reset` in 1: asynchronous, active-low
- `if_req` in 1: IF read request; held until `if_done`
- `if_addr` in ADDR_BITS: IF address; stable while `if_req` is high
- `if_gnt` out 1: one-cycle pulse when IF wins arbitration
- `if_done` out 1: one-cycle pulse; `if_rdata` is valid in this cycle
- `if_rdata` out DATA_BITS: read data; holds its value until the next IF read
- `ls_req` in 1: LS request; held until `ls_done`
- `ls_we` in 1: 1 = store, 0 = load
- `ls_addr` in ADDR_BITS: LS address
- `ls_wdata` in DATA_BITS: store data
- `ls_gnt`, `ls_done` out 1: same meaning as the IF signals
- `ls_rdata` out DATA_BITS: load data
- `mem_address` out ADDR_BITS: RAM address
- `mem_out_en` out 1: RAM read enable
- `mem_write_en` out 1: RAM write strobe
- `mem_wr_data` out DATA_BITS: data for the RAM inout net
- `mem_drive_en` out 1: enables the tristate drive of `mem_wr_data` onto the RAM data net
- `mem_rd_data` in DATA_BITS: RAM data net as read back

## Operation
- States: IDLE, RD_ISSUE, RD_CAPTURE, WR_SETUP, WR_COMMIT.
- **IDLE**, at a rising edge with any request high:
  - Pick the winner: LS if `ls_req`, unless the starve count equals `STARVE_LIMIT` and `if_req` is high, in which case IF.
  - Latch the owner, address, `we` and `wdata`, and pulse the owner's `gnt`.
  - Go to WR_SETUP if LS and `ls_we` is 1; otherwise go to RD_ISSUE.
- **RD_ISSUE**: `mem_address` = latched address, `mem_out_en` = 1. Next state is RD_CAPTURE.
- **RD_CAPTURE**: `mem_out_en` stays 1. At the edge:
  - Capture `mem_rd_data` into the owner's `rdata`.
  - Pulse the owner's `done`.
  - Set `mem_out_en` to 0 and go to IDLE.
- **WR_SETUP**: `mem_address`, `mem_wr_data` = latched data, `mem_drive_en` = 1, `mem_write_en` = 0. Next state is WR_COMMIT.
- **WR_COMMIT**: `mem_write_en` = 1 and `mem_drive_en` = 1, for exactly this one cycle. At the edge, pulse `ls_done`, clear both enables and go to IDLE.
- `mem_write_en` and `mem_out_en` are never high in the same cycle.
- Starve counter:
  - Increments on each LS grant made while `if_req` is high.
  - Clears on an IF grant, or on any IDLE edge where `if_req` is low.
  - Saturates at `STARVE_LIMIT`.
- If a request is high at the IDLE edge that follows its `done`, it is a new request. Requesters drop `req` during the `done` cycle unless they want back-to-back accesses.
- `ls_we` is ignored for IF; IF only reads.
- `if_req` and `ls_req` may both rise in the same cycle; the arbitration rule above resolves them.

## Timing
- Reset (async assert) sets:
  - state = IDLE
  - all `gnt` and `done` outputs = 0
  - `mem_out_en`, `mem_write_en`, `mem_drive_en` = 0
  - `mem_address`, `mem_wr_data`, `if_rdata`, `ls_rdata` = 0
  - starve count = 0
- Reset asserted mid-transaction aborts it: no `done` is issued, and no write strobe occurs if reset is asserted before the WR_COMMIT edge.
- Deassertion takes effect at the first rising edge after release.
- Read: request sampled at edge E0 → `gnt` high E0–E1 → RD_ISSUE E0–E1 → RD_CAPTURE E1–E2 → `done` and `rdata` valid E2–E3. That is 3 edges from request to done.
- Write: same edges; `mem_write_en` is high E1–E2 and `ls_done` is high E2–E3.
- Peak throughput: one transaction per 3 cycles.
- All outputs are registered.

## Structure
- Add to `constants_pkg`:
  - `typedef enum bit [2:0] arb_state_t` (the five states)
  - `typedef enum bit owner_t {OWN_IF, OWN_LS}`
  - `localparam ARB_STARVE_LIMIT`
- Widths reuse `MEMORY_ADDRESS_BITS` and `MEMORY_DATA_BITS`.
- One sub-module, `mem_grant_select`: the combinational winner pick plus the saturating starve counter, with ports `clk`, `reset`, `if_req`, `ls_req`, `grant_now`, `win_ls`.

## Test plan
- IF only: `if_req`, `if_addr`=0x00, RAM[0]=0xA5 → `if_gnt` at E0, `if_done` at E2, `if_rdata`=0xA5, `mem_write_en` never high.
- LS store then load: store 0x3C to 0x10, then load 0x10 → `mem_write_en` high for exactly one cycle (E1–E2) with `mem_address`=0x10, `mem_drive_en` high E0–E2; the load returns `ls_rdata`=0x3C.
- Simultaneous IF and LS request at E0 → LS granted first; IF granted at the next IDLE edge; both `done` pulses arrive in order, 3 cycles apart.
- Starvation: `if_req` held high while LS issues back-to-back requests, `STARVE_LIMIT`=3 → LS granted 3 times, the 4th grant goes to IF, the counter clears.
- Reset dropped during WR_SETUP → no `mem_write_en` pulse, RAM unchanged, all outputs 0; after release, a fresh IF request completes normally.
- Back-to-back IF reads at 0x00 and 0x01 with `req` held across `done` → grants 3 cycles apart, `if_rdata` matches RAM each time.
